// File: rtl/sar_scheduler.sv
// Round-robin scheduler that time-shares one SAR ADC between NCH requesters:
// grant, settle the input mux, toggle soc, collect eoc (or time out), ack the requester.
module sar_scheduler #(
  parameter int NCH     = 4,
  parameter int NBITS   = 10,
  parameter int SETTLE  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                                f100m_clk,
  input  logic                                rstb,
  input  logic [NCH-1:0]                      req,
  output logic [NCH-1:0]                      ack,
  output logic [NBITS-1:0]                    data_o,
  output logic                                data_err,
  output logic                                data_warn,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] mux_sel,
  output logic                                soc,
  input  logic                                eoc,
  input  logic                                err,
  input  logic                                warn,
  input  logic [NBITS-1:0]                    sar_code,
  output logic                                busy,
  output logic                                timeout_o
);

  localparam int MW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CONVERT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [MW-1:0]     ptr_q, ptr_d;
  logic [MW-1:0]     mux_sel_q, mux_sel_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              err_lat_q, err_lat_d;
  logic              warn_lat_q, warn_lat_d;
  logic [NCH-1:0]    ack_q, ack_d;
  logic [NBITS-1:0]  data_q, data_d;
  logic              data_err_q, data_err_d;
  logic              data_warn_q, data_warn_d;
  logic              soc_q, soc_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;

  logic              found;
  logic [MW-1:0]     g_idx;
  int                idx;

  // First pending request at or above ptr, wrapping modulo NCH.
  always_comb begin
    found = 1'b0;
    g_idx = '0;
    idx   = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && req[idx]) begin
        found = 1'b1;
        g_idx = MW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mux_sel_d   = mux_sel_q;
    settle_d    = settle_q;
    tcnt_d      = tcnt_q;
    err_lat_d   = err_lat_q;
    warn_lat_d  = warn_lat_q;
    ack_d       = '0;
    data_d      = data_q;
    data_err_d  = data_err_q;
    data_warn_d = data_warn_q;
    soc_d       = soc_q;
    timeout_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          mux_sel_d = g_idx;
          settle_d  = SW'(SETTLE - 1);
          ptr_d     = (g_idx == MW'(NCH - 1)) ? '0 : g_idx + 1'b1;
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          soc_d      = ~soc_q;
          tcnt_d     = '0;
          err_lat_d  = 1'b0;
          warn_lat_d = 1'b0;
          state_d    = S_CONVERT;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      S_CONVERT: begin
        err_lat_d  = err_lat_q | err;
        warn_lat_d = warn_lat_q | warn;
        // eoc wins over a timeout landing on the same cycle.
        if (eoc) begin
          data_d           = sar_code;
          data_err_d       = err_lat_q | err;
          data_warn_d      = warn_lat_q | warn;
          ack_d[mux_sel_q] = 1'b1;
          state_d          = S_DONE;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          data_d           = '0;
          data_err_d       = 1'b1;
          data_warn_d      = warn_lat_q | warn;
          ack_d[mux_sel_q] = 1'b1;
          timeout_d        = 1'b1;
          state_d          = S_DONE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge f100m_clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      mux_sel_q   <= '0;
      settle_q    <= '0;
      tcnt_q      <= '0;
      err_lat_q   <= 1'b0;
      warn_lat_q  <= 1'b0;
      ack_q       <= '0;
      data_q      <= '0;
      data_err_q  <= 1'b0;
      data_warn_q <= 1'b0;
      soc_q       <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mux_sel_q   <= mux_sel_d;
      settle_q    <= settle_d;
      tcnt_q      <= tcnt_d;
      err_lat_q   <= err_lat_d;
      warn_lat_q  <= warn_lat_d;
      ack_q       <= ack_d;
      data_q      <= data_d;
      data_err_q  <= data_err_d;
      data_warn_q <= data_warn_d;
      soc_q       <= soc_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign ack       = ack_q;
  assign data_o    = data_q;
  assign data_err  = data_err_q;
  assign data_warn = data_warn_q;
  assign mux_sel   = mux_sel_q;
  assign soc       = soc_q;
  assign busy      = busy_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_sar_scheduler.sv
// Bench for sar_scheduler: table of conversions driven through a SAR/requester model,
// acks checked against a scoreboard queue, plus hand-written reset and stray-event sequences.
module tb_sar_scheduler;

  localparam int NCH     = 4;
  localparam int NBITS   = 10;
  localparam int SETTLE  = 8;
  localparam int TIMEOUT = 255;

  logic             f100m_clk = 1'b0;
  logic             rstb      = 1'b0;
  logic [NCH-1:0]   req       = '0;
  logic [NCH-1:0]   ack;
  logic [NBITS-1:0] data_o;
  logic             data_err;
  logic             data_warn;
  logic [1:0]       mux_sel;
  logic             soc;
  logic             eoc       = 1'b0;
  logic             err       = 1'b0;
  logic             warn      = 1'b0;
  logic [NBITS-1:0] sar_code  = '0;
  logic             busy;
  logic             timeout_o;

  sar_scheduler #(.NCH(NCH), .NBITS(NBITS), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .f100m_clk (f100m_clk),
    .rstb      (rstb),
    .req       (req),
    .ack       (ack),
    .data_o    (data_o),
    .data_err  (data_err),
    .data_warn (data_warn),
    .mux_sel   (mux_sel),
    .soc       (soc),
    .eoc       (eoc),
    .err       (err),
    .warn      (warn),
    .sar_code  (sar_code),
    .busy      (busy),
    .timeout_o (timeout_o)
  );

  always #5 f100m_clk = ~f100m_clk;

  typedef struct {
    int               ch;
    logic [NBITS-1:0] data;
    logic             err;
    logic             warn;
    logic             to;
  } exp_t;

  // eoc_dly: CONVERT cycle carrying eoc (0 = never, forces timeout); err_at/warn_at likewise (-1 = none).
  typedef struct {
    logic [NCH-1:0]   req_add;
    logic [NBITS-1:0] code;
    int               eoc_dly;
    int               err_at;
    int               warn_at;
    bit               stray;
    int               exp_ch;
    logic             exp_err;
    logic             exp_warn;
  } vec_t;

  exp_t sb[$];
  int   nchk    = 0;
  int   nfail   = 0;
  int   ack_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requester model and scoreboard consumer: drop req on ack, compare result.
  initial begin : monitor
    bit   chk_next;
    exp_t e;
    chk_next = 1'b0;
    forever begin
      @(negedge f100m_clk);
      if (!rstb) begin
        chk_next = 1'b0;
        continue;
      end
      if (chk_next) begin
        check("ack_single_cycle", ack, 0);
        check("busy_after_done", busy, 0);
        chk_next = 1'b0;
      end
      if (ack != '0) begin
        if (sb.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL unexpected_ack: got %b expected none", ack);
        end else begin
          e = sb.pop_front();
          check("ack_onehot", ack, 32'(1) << e.ch);
          check("data_o", data_o, e.data);
          check("data_err", data_err, e.err);
          check("data_warn", data_warn, e.warn);
          check("timeout_o", timeout_o, e.to);
          $display("ack ch=%0d data=%h err=%b warn=%b timeout=%b", e.ch, data_o, data_err, data_warn, timeout_o);
        end
        chk_next = 1'b1;
        ack_cnt++;
        req = req & ~ack;
      end else if (timeout_o) begin
        nchk++;
        nfail++;
        $display("FAIL stray_timeout: got 1 expected 0");
      end
    end
  end

  task automatic step();
    @(negedge f100m_clk);
    #1;
  endtask

  task automatic do_conv(input vec_t v, input int exp_lat);
    exp_t e;
    bit   to;
    int   last, lat, target, w;
    logic s0;
    to     = (v.eoc_dly == 0);
    last   = to ? TIMEOUT : v.eoc_dly;
    e.ch   = v.exp_ch;
    e.data = to ? '0 : v.code;
    e.err  = v.exp_err;
    e.warn = v.exp_warn;
    e.to   = to;
    target = ack_cnt + 1;
    req    = req | v.req_add;
    sb.push_back(e);
    s0  = soc;
    lat = 0;
    while (soc == s0 && lat < 40) begin
      step();
      lat++;
      eoc = v.stray && (lat == 3);
    end
    eoc = 1'b0;
    check("soc_latency", lat, exp_lat);
    check("mux_sel", mux_sel, v.exp_ch);
    check("busy_convert", busy, 1);
    sar_code = v.code;
    for (int c = 1; c <= last; c++) begin
      eoc  = (c == v.eoc_dly);
      err  = (c == v.err_at);
      warn = (c == v.warn_at);
      step();
    end
    eoc  = 1'b0;
    err  = 1'b0;
    warn = 1'b0;
    w = 0;
    while (ack_cnt != target && w < 10) begin
      step();
      w++;
    end
    check("ack_seen", ack_cnt, target);
  endtask

  vec_t tbl[11];
  vec_t v;
  int   lat;
  logic s0;

  initial begin
    tbl[0]  = '{4'b0100, 10'h2A5,  20, -1, -1, 1'b0, 2, 1'b0, 1'b0};
    tbl[1]  = '{4'b1111, 10'h111,   3, -1, -1, 1'b0, 3, 1'b0, 1'b0};
    tbl[2]  = '{4'b0000, 10'h000,   4, -1, -1, 1'b0, 0, 1'b0, 1'b0};
    tbl[3]  = '{4'b0000, 10'h155,   5, -1, -1, 1'b0, 1, 1'b0, 1'b0};
    tbl[4]  = '{4'b0001, 10'h0AA,   6, -1, -1, 1'b0, 2, 1'b0, 1'b0};
    tbl[5]  = '{4'b0000, 10'h0F0,   7, -1, -1, 1'b0, 0, 1'b0, 1'b0};
    tbl[6]  = '{4'b0010, 10'h3FF,  10,  4, 10, 1'b0, 1, 1'b1, 1'b1};
    tbl[7]  = '{4'b0100, 10'h123,   3, -1, -1, 1'b1, 2, 1'b0, 1'b0};
    tbl[8]  = '{4'b1001, 10'h155,   0, -1, 50, 1'b0, 3, 1'b1, 1'b1};
    tbl[9]  = '{4'b0000, 10'h321,   2, -1, -1, 1'b0, 0, 1'b0, 1'b0};
    tbl[10] = '{4'b0010, 10'h2C1, 255, -1, -1, 1'b0, 1, 1'b0, 1'b0};

    repeat (3) step();
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_soc", soc, 0);
    check("rst_mux_sel", mux_sel, 0);
    rstb = 1'b1;

    // eoc in IDLE must be ignored.
    eoc = 1'b1;
    step();
    eoc = 1'b0;
    repeat (3) step();
    check("idle_eoc_busy", busy, 0);
    check("idle_eoc_soc", soc, 0);

    for (int i = 0; i < 11; i++) do_conv(tbl[i], (i == 0) ? 9 : 10);

    // Reset in the middle of CONVERT.
    req = 4'b0010;
    s0  = soc;
    lat = 0;
    while (soc == s0 && lat < 40) begin
      step();
      lat++;
    end
    check("pre_reset_grant", mux_sel, 1);
    repeat (5) step();
    rstb = 1'b0;
    #1;
    check("async_rst_ack", ack, 0);
    check("async_rst_data_o", data_o, 0);
    check("async_rst_data_err", data_err, 0);
    check("async_rst_data_warn", data_warn, 0);
    check("async_rst_mux_sel", mux_sel, 0);
    check("async_rst_soc", soc, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_timeout", timeout_o, 0);
    req = 4'b1010;
    repeat (3) step();
    check("in_rst_ack", ack, 0);
    rstb = 1'b1;
    v = '{4'b0000, 10'h0C3, 6, -1, -1, 1'b0, 1, 1'b0, 1'b0};
    do_conv(v, 9);
    v = '{4'b0000, 10'h3C0, 3, -1, -1, 1'b0, 3, 1'b0, 1'b0};
    do_conv(v, 10);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
